// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// The WB_BYPASS_EN build option is consumed by wb_fifo and wb_scheduler.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 4;
    localparam int WB_DW    = 32;

    localparam logic [WB_AW-1:0] REG_PC = WB_AW'(15);

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer with two push ports and a 0/1/2 pop count.
// With WB_BYPASS_EN defined it also exposes every slot in age order with valid bits.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push0,
    input  wb_entry_t                push0_entry,
    input  logic                     push1,
    input  wb_entry_t                push1_entry,
    input  logic [1:0]               pop_cnt,
    output wb_entry_t                head0,
    output wb_entry_t                head1,
    output logic [$clog2(DEPTH):0]   count
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         entry_valid
`endif
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr1;
    logic [PW-1:0]   wr_ptr1;
    logic [PW:0]     count_next;

    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    always_comb begin
        count_next = count + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(pop_cnt);
    end

    // Channel 0 is older, so it takes the first free slot when both push.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wr_ptr] <= push0_entry;
        end
        if (push1) begin
            mem[push0 ? wr_ptr1 : wr_ptr] <= push1_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_ptr + PW'(pop_cnt);
            count  <= count_next;
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr1];

`ifdef WB_BYPASS_EN
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            entries[a]     = mem[rd_ptr + PW'(a)];
            entry_valid[a] = ((PW+1)'(a) < count);
        end
    end
`endif

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: queues ALU/multiplier results, retires up to two per cycle,
// and steers R15 writes to the PC port. WB_BYPASS_EN adds a forwarding lookup.
module wb_scheduler
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          res0_valid,
    output logic          res0_ready,
    input  logic [AW-1:0] res0_addr,
    input  logic [DW-1:0] res0_data,
    input  logic          res1_valid,
    output logic          res1_ready,
    input  logic [AW-1:0] res1_addr,
    input  logic [DW-1:0] res1_data,
    output logic [AW-1:0] write_address,
    output logic [DW-1:0] write_data,
    output logic          write_enable,
    output logic [AW-1:0] write_address2,
    output logic [DW-1:0] write_data2,
    output logic          write_enable2,
    output logic [DW-1:0] pc_update,
    output logic          pc_write,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            push0;
    logic            push1;
    wb_entry_t       push0_entry;
    wb_entry_t       push1_entry;
    wb_entry_t       head0;
    wb_entry_t       head1;
    logic [CW-1:0]   count;
    logic [1:0]      pop_cnt;
    logic            issue1;
    logic            issue2;
    logic            issue_pc;

`ifdef WB_BYPASS_EN
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] entry_valid;
`endif

    // Readiness depends on the registered count only, never on valid.
    assign res0_ready = (count <= CW'(DEPTH - 1));
    assign res1_ready = (count <= CW'(DEPTH - 2));

    assign push0 = res0_valid & res0_ready;
    assign push1 = res1_valid & res1_ready;

    assign push0_entry = '{addr: res0_addr, data: res0_data};
    assign push1_entry = '{addr: res1_addr, data: res1_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (push1_entry),
        .pop_cnt     (pop_cnt),
        .head0       (head0),
        .head1       (head1),
        .count       (count)
`ifdef WB_BYPASS_EN
        ,
        .entries     (entries),
        .entry_valid (entry_valid)
`endif
    );

    // A PC write retires alone; a second regfile write needs a distinct, non-PC address.
    always_comb begin
        issue1   = 1'b0;
        issue2   = 1'b0;
        issue_pc = 1'b0;
        pop_cnt  = 2'd0;
        if (count != CW'(0)) begin
            if (head0.addr == REG_PC) begin
                issue_pc = 1'b1;
                pop_cnt  = 2'd1;
            end else begin
                issue1  = 1'b1;
                pop_cnt = 2'd1;
                if ((count >= CW'(2)) && (head1.addr != REG_PC) &&
                    (head1.addr != head0.addr)) begin
                    issue2  = 1'b1;
                    pop_cnt = 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_enable   <= 1'b0;
            write_enable2  <= 1'b0;
            pc_write       <= 1'b0;
            write_address  <= '0;
            write_data     <= '0;
            write_address2 <= '0;
            write_data2    <= '0;
            pc_update      <= '0;
        end else begin
            write_enable  <= issue1;
            write_enable2 <= issue2;
            pc_write      <= issue_pc;
            if (issue1) begin
                write_address <= head0.addr;
                write_data    <= head0.data;
            end
            if (issue2) begin
                write_address2 <= head1.addr;
                write_data2    <= head1.data;
            end
            if (issue_pc) begin
                pc_update <= head0.data;
            end
        end
    end

    assign busy = (count != CW'(0)) | write_enable | write_enable2 | pc_write;

`ifdef WB_BYPASS_EN
    // Later matches override earlier ones: issuing writes are oldest, then queue head to tail.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (write_enable && (write_address == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data;
        end
        if (pc_write && (fwd_addr == REG_PC)) begin
            fwd_hit  = 1'b1;
            fwd_data = pc_update;
        end
        if (write_enable2 && (write_address2 == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data2;
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (entry_valid[a] && (entries[a].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[a].data;
            end
        end
    end
`endif

endmodule
